disp_scan: RTL and testbench

Upstream display-scan stage for the 10-bit processor's 4-digit multiplexed seven-segment display. It latches a 10-bit value on a load strobe and stores it as four display nibbles. It then time-multiplexes those nibbles onto a single 4-bit digit bus that feeds the seven-segment decoder, and drives the active-low digit-enable lines in step. A compile-time option inserts a sequential binary-to-BCD converter so the value is shown in decimal instead of hex.

---
 rtl/disp_scan.sv | 98 +++++++++
 tb/tb_disp_scan.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/disp_scan.sv
// Display scan for a 4-digit muxed seven-segment display: latches a 10-bit value
// and time-multiplexes its nibbles. Define DISP_BCD_EN for a decimal (double-dabble) build.
module disp_scan #(
  parameter int DIV_W   = 16,
  parameter int DIV_MAX = 49999
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [9:0] value,
  output logic       busy,
  output logic [3:0] digit,
  output logic [3:0] an
);

  localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(DIV_MAX);

  logic [15:0]      disp_val;
  logic [1:0]       idx;
  logic [DIV_W-1:0] div;

  // Refresh scan runs unconditionally; only reset stops it.
  always_ff @(posedge clk) begin
    if (reset) begin
      div <= '0;
      idx <= '0;
    end else if (div == DIV_TC) begin
      div <= '0;
      idx <= idx + 2'd1;
    end else begin
      div <= div + 1'b1;
    end
  end

  assign an = ~(4'b0001 << idx);

  always_comb begin
    digit = disp_val[3:0];
    case (idx)
      2'd0: digit = disp_val[3:0];
      2'd1: digit = disp_val[7:4];
      2'd2: digit = disp_val[11:8];
      2'd3: digit = disp_val[15:12];
      default: digit = disp_val[3:0];
    endcase
  end

`ifdef DISP_BCD_EN
  logic [9:0]  sh, sh_n;
  logic [15:0] acc, adj, acc_n;
  logic [3:0]  cnt;
  logic        bsy;

  // One double-dabble iteration: adjust nibbles >= 5, then shift {acc, sh} left.
  always_comb begin
    adj = acc;
    for (int i = 0; i < 4; i++)
      if (acc[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    acc_n = {adj[14:0], sh[9]};
    sh_n  = {sh[8:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      disp_val <= '0;
      sh       <= '0;
      acc      <= '0;
      cnt      <= '0;
      bsy      <= 1'b0;
    end else if (!bsy) begin
      if (load) begin
        sh  <= value;
        acc <= '0;
        cnt <= '0;
        bsy <= 1'b1;
      end
    end else begin
      acc <= acc_n;
      sh  <= sh_n;
      cnt <= cnt + 4'd1;
      if (cnt == 4'd9) begin
        disp_val <= acc_n;
        bsy      <= 1'b0;
      end
    end
  end

  assign busy = bsy;
`else
  always_ff @(posedge clk) begin
    if (reset)     disp_val <= '0;
    else if (load) disp_val <= {6'b0, value};
  end

  assign busy = 1'b0;
`endif

endmodule

// File: tb/tb_disp_scan.sv
// Directed bench for disp_scan: three instances (DIV_MAX = 0, 1, 3) share inputs;
// a small scan model supplies the expected digit index for each.
module tb_disp_scan;

  logic       clk = 1'b0;
  logic       reset, load;
  logic [9:0] value;
  logic [2:0] busy_o;
  logic [3:0] digit_o [3];
  logic [3:0] an_o [3];

  int n_cmp = 0;
  int n_bad = 0;

  // Model state per instance: 0 -> DIV_MAX=0, 1 -> DIV_MAX=1, 2 -> DIV_MAX=3
  int          dmax [3] = '{0, 1, 3};
  int          mdiv [3];
  int          midx [3];
  logic [15:0] mval [3];

  always #5 clk = ~clk;

  disp_scan #(.DIV_W(4), .DIV_MAX(0)) u0 (
    .clk(clk), .reset(reset), .load(load), .value(value),
    .busy(busy_o[0]), .digit(digit_o[0]), .an(an_o[0]));
  disp_scan #(.DIV_W(4), .DIV_MAX(1)) u1 (
    .clk(clk), .reset(reset), .load(load), .value(value),
    .busy(busy_o[1]), .digit(digit_o[1]), .an(an_o[1]));
  disp_scan #(.DIV_W(4), .DIV_MAX(3)) u3 (
    .clk(clk), .reset(reset), .load(load), .value(value),
    .busy(busy_o[2]), .digit(digit_o[2]), .an(an_o[2]));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, updating the model with the inputs sampled on it, then settle.
  task automatic tick();
    @(posedge clk);
    for (int u = 0; u < 3; u++) begin
      if (reset) begin
        mdiv[u] = 0; midx[u] = 0; mval[u] = '0;
      end else begin
`ifndef DISP_BCD_EN
        if (load) mval[u] = {6'b0, value};
`endif
        if (mdiv[u] == dmax[u]) begin mdiv[u] = 0; midx[u] = (midx[u] + 1) % 4; end
        else mdiv[u] = mdiv[u] + 1;
      end
    end
    #1;
  endtask

  task automatic check_frame(input int u, input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      tick();
      chk({tag, "_an"}, {12'b0, an_o[u]}, {12'b0, ~(4'b0001 << midx[u])});
      chk({tag, "_dig"}, {12'b0, digit_o[u]}, {12'b0, mval[u][4*midx[u] +: 4]});
    end
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; value = '0;
    #1;
    // Reset held two cycles: idx stays 0, an=1110, digit 0.
    for (int k = 0; k < 2; k++) begin
      tick();
      for (int u = 0; u < 3; u++) begin
        chk("rst_an", {12'b0, an_o[u]}, 16'h000E);
        chk("rst_dig", {12'b0, digit_o[u]}, 16'h0000);
        chk("rst_busy", {15'b0, busy_o[u]}, 16'h0000);
      end
    end

`ifndef DISP_BCD_EN
    // Hex scan, DIV_MAX=3: 10'h3A5 -> 5, A, 3, 0 then wrap.
    reset = 1'b0; load = 1'b1; value = 10'h3A5;
    tick();
    chk("hex_first_dig", {12'b0, digit_o[2]}, 16'h0005);
    chk("hex_first_an", {12'b0, an_o[2]}, 16'h000E);
    load = 1'b0;
    check_frame(2, 18, "hex3");
    chk("hex_busy", {15'b0, busy_o[2]}, 16'h0000);

    // Another pattern on DIV_MAX=1.
    load = 1'b1; value = 10'h1C6;
    tick();
    load = 1'b0;
    check_frame(1, 9, "hex1");

    // Reset together with load: nothing captured.
    reset = 1'b1; load = 1'b1; value = 10'h3FF;
    tick();
    reset = 1'b0; load = 1'b0;
    chk("rstld_dig", {12'b0, digit_o[1]}, 16'h0000);
    check_frame(1, 8, "rstld");

    // Load on an idx-advance edge (DIV_MAX=1): realign with a reset first.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk("adv_pre_an", {12'b0, an_o[1]}, 16'h000E);
    chk("adv_pre_dig", {12'b0, digit_o[1]}, 16'h0000);
    load = 1'b1; value = 10'h0F0;
    tick();
    load = 1'b0;
    chk("adv_an", {12'b0, an_o[1]}, 16'h000D);
    chk("adv_dig", {12'b0, digit_o[1]}, 16'h000F);
    check_frame(1, 8, "adv");
`else
    // BCD, DIV_MAX=0: 1023 -> digits 3,2,0,1; busy exactly 10 cycles.
    reset = 1'b0; load = 1'b1; value = 10'd1023;
    tick();
    load = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk("bcd_busy", {15'b0, busy_o[0]}, 16'h0001);
      chk("bcd_hold", {12'b0, digit_o[0]}, 16'h0000);
      tick();
    end
    chk("bcd_done", {15'b0, busy_o[0]}, 16'h0000);
    mval[0] = 16'h1023;
    chk("bcd_dig_now", {12'b0, digit_o[0]}, {12'b0, mval[0][4*midx[0] +: 4]});
    check_frame(0, 4, "bcd1023");

    // 0 -> all zeros.
    load = 1'b1; value = 10'd0;
    tick();
    load = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    chk("bcd0_busy", {15'b0, busy_o[0]}, 16'h0000);
    mval[0] = 16'h0000;
    check_frame(0, 4, "bcd0");

    // Load while busy is ignored.
    load = 1'b1; value = 10'd999;
    tick();
    load = 1'b0;
    tick(); tick();
    load = 1'b1; value = 10'd5;
    tick();
    load = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    chk("ign_busy9", {15'b0, busy_o[0]}, 16'h0001);
    tick();
    chk("ign_busy10", {15'b0, busy_o[0]}, 16'h0000);
    mval[0] = 16'h0999;
    check_frame(0, 8, "bcd999");

    // Reset at the 5th busy cycle aborts the conversion.
    load = 1'b1; value = 10'd512;
    tick();
    load = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("abort_pre", {15'b0, busy_o[0]}, 16'h0001);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", {15'b0, busy_o[0]}, 16'h0000);
    check_frame(0, 12, "abort");
    chk("abort_busy_end", {15'b0, busy_o[0]}, 16'h0000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
